// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the CPU run controller: FSM states, mode codes, step targets.
// State codes are plain localparams so legacy tools and waveforms see fixed values.
package cpu_dbg_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ISSUE  = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_RUN    = 3'd3;
  localparam state_t ST_RUN_BP = 3'd4;
  localparam state_t ST_BREAK  = 3'd5;

  localparam logic [1:0] MODE_BEAT   = 2'b00;
  localparam logic [1:0] MODE_INSTR  = 2'b01;
  localparam logic [1:0] MODE_RUN    = 2'b10;
  localparam logic [1:0] MODE_RUN_BP = 2'b11;

  typedef logic tgt_t;
  localparam tgt_t TGT_BEAT  = 1'b0;
  localparam tgt_t TGT_INSTR = 1'b1;

  localparam logic [4:0] FETCH_BEAT_DEF = 5'b00001;

  function automatic logic is_run_state(input state_t st);
    return (st == ST_RUN) || (st == ST_RUN_BP);
  endfunction

endpackage

// File: rtl/ce_tick_gen.sv
// Prescaler for run modes: tick is high for one cycle every PRESCALE cycles after clr drops.
module ce_tick_gen #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt_q;

  assign tick = !clr && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution sequencer: drives a one-cycle cpu_ce for beat/instr stepping, free run and
// run-to-breakpoint. Define CYCLE_LIMIT_EN to abort runs after MAX_RUN pulses.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned PRESCALE   = 4,
  parameter logic [4:0]  FETCH_BEAT = FETCH_BEAT_DEF,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_RUN    = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [1:0]       mode,
  input  logic [4:0]       beat,
  input  logic [31:0]      pc,
  input  logic [31:0]      bp_addr,
  output logic             cpu_ce,
  output logic             running,
  output logic             bp_hit,
  output logic             limit_hit,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [31:0] MAX_RUN_W = 32'(MAX_RUN);

  state_t           state_q, state_d;
  state_t           origin_q, origin_d;
  tgt_t             tgt_q, tgt_d;
  logic             skip_q, skip_d;
  logic             cpu_ce_q, running_q, bp_hit_q;
  logic [CNT_W-1:0] beat_cnt_q, instr_cnt_q;

  logic in_run;
  logic tick;
  logic run_pulse;
  logic ce_d;
  logic fetch_ce;
  logic bp_match;
  logic limit_reached;

  assign in_run   = is_run_state(state_q);
  assign bp_match = (beat == FETCH_BEAT) && (pc == bp_addr) && !skip_q;

  // Prescaler restarts on every entry to a run state since it is held clear elsewhere.
  ce_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (!in_run),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    origin_d  = origin_q;
    tgt_d     = tgt_q;
    skip_d    = skip_q;
    run_pulse = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          unique case (mode)
            MODE_BEAT: begin
              state_d  = ST_ISSUE;
              tgt_d    = TGT_BEAT;
              origin_d = ST_IDLE;
            end
            MODE_INSTR: begin
              state_d  = ST_ISSUE;
              tgt_d    = TGT_INSTR;
              origin_d = ST_IDLE;
            end
            MODE_RUN:    state_d = ST_RUN;
            MODE_RUN_BP: state_d = ST_RUN_BP;
          endcase
        end
      end
      ST_ISSUE: state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (tgt_q == TGT_BEAT) begin
          state_d = ST_IDLE;
        end else if (beat == FETCH_BEAT) begin
          state_d = origin_q;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_RUN, ST_RUN_BP: begin
        if (go) begin
          state_d = ST_IDLE;
        end else if (limit_reached) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          // The breakpoint is checked before the pulse so the target is never fetched.
          if ((state_q == ST_RUN_BP) && bp_match) begin
            state_d = ST_BREAK;
          end else begin
            run_pulse = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (go) begin
          skip_d   = 1'b1;
          state_d  = ST_ISSUE;
          tgt_d    = TGT_INSTR;
          origin_d = ST_RUN_BP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ce_d     = run_pulse || (state_d == ST_ISSUE);
    fetch_ce = ce_d && (beat == FETCH_BEAT);
    if (fetch_ce && skip_q) begin
      skip_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      origin_q    <= ST_IDLE;
      tgt_q       <= TGT_BEAT;
      skip_q      <= 1'b0;
      cpu_ce_q    <= 1'b0;
      running_q   <= 1'b0;
      bp_hit_q    <= 1'b0;
      beat_cnt_q  <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      origin_q  <= origin_d;
      tgt_q     <= tgt_d;
      skip_q    <= skip_d;
      cpu_ce_q  <= ce_d;
      running_q <= is_run_state(state_d);
      bp_hit_q  <= (state_d == ST_BREAK);
      if (ce_d) begin
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      end
      if (fetch_ce) begin
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef CYCLE_LIMIT_EN
  logic [31:0] run_cnt_q;
  logic        limit_q, limit_d;

  assign limit_reached = (run_cnt_q >= MAX_RUN_W);

  always_comb begin
    limit_d = limit_q;
    if (go) begin
      limit_d = 1'b0;
    end
    if (in_run && !go && limit_reached) begin
      limit_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q <= '0;
      limit_q   <= 1'b0;
    end else begin
      limit_q <= limit_d;
      if (!in_run) begin
        run_cnt_q <= '0;
      end else if (run_pulse) begin
        run_cnt_q <= run_cnt_q + 32'd1;
      end
    end
  end

  assign limit_hit = limit_q;
`else
  logic unused_max_run;
  assign unused_max_run = ^MAX_RUN_W;
  assign limit_reached  = 1'b0;
  assign limit_hit      = 1'b0;
`endif

  assign cpu_ce    = cpu_ce_q;
  assign running   = running_q;
  assign bp_hit    = bp_hit_q;
  assign beat_cnt  = beat_cnt_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a small datapath model (beat/pc) and a pulse monitor.
// Build with CYCLE_LIMIT_EN defined to exercise the run-pulse limit instead of the long runs.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;
  import cpu_dbg_pkg::*;

`ifdef CYCLE_LIMIT_EN
  localparam int unsigned MAXR = 8;
`else
  localparam int unsigned MAXR = 1000000;
`endif

  logic        clk = 1'b0;
  logic        rst, go;
  logic [1:0]  mode;
  logic [4:0]  beat;
  logic [31:0] pc, bp_addr;
  logic        cpu_ce, running, bp_hit, limit_hit;
  logic [15:0] beat_cnt, instr_cnt;

  int          ncmp = 0;
  int          nfail = 0;
  int unsigned nbeats = 4;
  int unsigned mdl_beats = 0;
  int unsigned mdl_instr = 0;
  logic        ce_prev = 1'b0;
  logic [4:0]  last_beat;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  cpu_run_ctrl #(
    .PRESCALE   (4),
    .FETCH_BEAT (5'b00001),
    .CNT_W      (16),
    .MAX_RUN    (MAXR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .mode      (mode),
    .beat      (beat),
    .pc        (pc),
    .bp_addr   (bp_addr),
    .cpu_ce    (cpu_ce),
    .running   (running),
    .bp_hit    (bp_hit),
    .limit_hit (limit_hit),
    .beat_cnt  (beat_cnt),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: one-hot beat advances on each cpu_ce, pc steps on wrap (8-instr loop).
  assign last_beat = 5'(32'd1 << (nbeats - 1));
  always @(posedge clk) begin
    if (rst) begin
      beat <= 5'b00001;
      pc   <= 32'h0;
    end else if (cpu_ce) begin
      if (beat == last_beat) begin
        beat <= 5'b00001;
        pc   <= (pc + 32'd4) & 32'h1F;
      end else begin
        beat <= beat << 1;
      end
    end
  end

  // Pulse monitor: width check and per-pulse counter check against an independent model.
  always @(negedge clk) begin
    if (rst) begin
      mdl_beats = 0;
      mdl_instr = 0;
      ce_prev   = 1'b0;
    end else begin
      if (cpu_ce) begin
        ncmp++;
        assert (ce_prev === 1'b0) else begin
          nfail++;
          $error("FAIL ce_width observed=wider expected=1 cycle");
        end
        mdl_beats++;
        if (beat == 5'b00001) mdl_instr++;
        ncmp++;
        assert (beat_cnt === 16'(mdl_beats)) else begin
          nfail++;
          $error("FAIL beat_cnt_pulse observed=%0d expected=%0d", beat_cnt, mdl_beats);
        end
        ncmp++;
        assert (instr_cnt === 16'(mdl_instr)) else begin
          nfail++;
          $error("FAIL instr_cnt_pulse observed=%0d expected=%0d", instr_cnt, mdl_instr);
        end
      end
      ce_prev = cpu_ce;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_go;
    go = 1'b1;
    cyc(1);
    go = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_v(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    ncmp++;
    if (exp_q.size() == 0) begin
      nfail++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        nfail++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic wait_state(input string tag, input state_t st, input int lim);
    int n = 0;
    while (dut.state_q !== st && n < lim) begin
      cyc(1);
      n++;
    end
    ncmp++;
    assert (dut.state_q === st) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, dut.state_q, st);
    end
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    while (dut.u_tick.tick !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    ncmp++;
    assert (dut.u_tick.tick === 1'b1) else begin
      nfail++;
      $error("FAIL %s observed=%0b expected=1", tag, dut.u_tick.tick);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; go = 1'b0; mode = MODE_BEAT; bp_addr = 32'hFFFF_FFFF;

    // Reset state
    expect_v("rst_cpu_ce", 0); expect_v("rst_running", 0); expect_v("rst_bp_hit", 0);
    expect_v("rst_limit", 0); expect_v("rst_beat_cnt", 0); expect_v("rst_instr_cnt", 0);
    expect_v("rst_state", 32'(ST_IDLE));
    do_reset;
    check_v(32'(cpu_ce)); check_v(32'(running)); check_v(32'(bp_hit));
    check_v(32'(limit_hit)); check_v(32'(beat_cnt)); check_v(32'(instr_cnt));
    check_v(32'(dut.state_q));

    // Beat step: one pulse, IDLE two cycles after the pulse cycle
    mode = MODE_BEAT;
    expect_v("step_ce_high", 1); expect_v("step_ce_low", 0); expect_v("step_state", 32'(ST_IDLE));
    expect_v("step_beat_cnt", 1); expect_v("step_instr_cnt", 1); expect_v("step_pulses", 1);
    pulse_go;
    check_v(32'(cpu_ce));
    cyc(1);
    check_v(32'(cpu_ce));
    cyc(1);
    check_v(32'(dut.state_q));
    cyc(3);
    check_v(32'(beat_cnt)); check_v(32'(instr_cnt)); check_v(mdl_beats);

    // Instruction step over a 4-beat instruction
    do_reset;
    nbeats = 4;
    mode = MODE_INSTR;
    expect_v("istep_beat_cnt", 4); expect_v("istep_instr_cnt", 1);
    expect_v("istep_beat", 32'h1); expect_v("istep_pc", 32'h4);
    pulse_go;
    wait_state("istep_idle", ST_IDLE, 40);
    check_v(32'(beat_cnt)); check_v(32'(instr_cnt)); check_v(32'(beat)); check_v(pc);

    // Breakpoint at the first fetch after reset
    do_reset;
    nbeats = 3;
    bp_addr = 32'h0;
    mode = MODE_RUN_BP;
    expect_v("bp0_bp_hit", 1); expect_v("bp0_beat_cnt", 0); expect_v("bp0_pc", 0);
    pulse_go;
    wait_state("bp0_break", ST_BREAK, 10);
    check_v(32'(bp_hit)); check_v(32'(beat_cnt)); check_v(pc);

`ifndef CYCLE_LIMIT_EN
    // Free run, 40 cycles, mode change ignored mid-run
    do_reset;
    mode = MODE_RUN;
    expect_v("run_running", 1); expect_v("run_running_late", 1);
    expect_v("run_stop_ce", 0); expect_v("run_stop_state", 32'(ST_IDLE));
    expect_v("run_stop_running", 0); expect_v("run_pulses", 10);
    pulse_go;
    cyc(20);
    check_v(32'(running));
    mode = MODE_BEAT;
    cyc(20);
    check_v(32'(running));
    pulse_go;
    check_v(32'(cpu_ce)); check_v(32'(dut.state_q)); check_v(32'(running));
    cyc(2);
    check_v(mdl_beats);

    // Run to breakpoint at 0x0C with 3-beat instructions, then resume
    do_reset;
    nbeats = 3;
    bp_addr = 32'h0000_000C;
    mode = MODE_RUN_BP;
    expect_v("bp_hit", 1); expect_v("bp_pc", 32'hC); expect_v("bp_beat", 32'h1);
    expect_v("bp_instr_cnt", 3); expect_v("bp_beat_cnt", 9); expect_v("bp_running", 0);
    pulse_go;
    wait_state("bp_break", ST_BREAK, 200);
    check_v(32'(bp_hit)); check_v(pc); check_v(32'(beat)); check_v(32'(instr_cnt));
    check_v(32'(beat_cnt)); check_v(32'(running));
    expect_v("resume_pc", 32'h10); expect_v("resume_bp_hit", 0);
    expect_v("resume_instr_cnt", 4); expect_v("resume_beat_cnt", 12);
    pulse_go;
    wait_state("resume_runbp", ST_RUN_BP, 30);
    check_v(pc); check_v(32'(bp_hit)); check_v(32'(instr_cnt)); check_v(32'(beat_cnt));
    expect_v("bp2_pc", 32'hC); expect_v("bp2_instr_cnt", 11); expect_v("bp2_beat_cnt", 33);
    wait_state("bp2_break", ST_BREAK, 400);
    check_v(pc); check_v(32'(instr_cnt)); check_v(32'(beat_cnt));

    // go coinciding with a tick: no pulse, back to IDLE
    do_reset;
    mode = MODE_RUN;
    pulse_go;
    cyc(6);
    wait_tick("gotick_tick");
    expect_v("gotick_ce", 0); expect_v("gotick_state", 32'(ST_IDLE)); expect_v("gotick_pulses", 1);
    go = 1'b1;
    cyc(1);
    go = 1'b0;
    check_v(32'(cpu_ce)); check_v(32'(dut.state_q));
    cyc(2);
    check_v(mdl_beats);

    // rst while a pulse is pending
    pulse_go;
    cyc(6);
    wait_tick("rstrun_tick");
    expect_v("rstrun_ce", 0); expect_v("rstrun_running", 0); expect_v("rstrun_bp_hit", 0);
    expect_v("rstrun_limit", 0); expect_v("rstrun_beat_cnt", 0); expect_v("rstrun_instr_cnt", 0);
    expect_v("rstrun_state", 32'(ST_IDLE));
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check_v(32'(cpu_ce)); check_v(32'(running)); check_v(32'(bp_hit));
    check_v(32'(limit_hit)); check_v(32'(beat_cnt)); check_v(32'(instr_cnt));
    check_v(32'(dut.state_q));
`else
    // Run aborted after MAX_RUN pulses; next go clears limit_hit
    do_reset;
    mode = MODE_RUN;
    expect_v("lim_pulses", 8); expect_v("lim_hit", 1); expect_v("lim_clear", 0);
    pulse_go;
    cyc(2);
    wait_state("lim_idle", ST_IDLE, 100);
    cyc(6);
    check_v(mdl_beats); check_v(32'(limit_hit));
    mode = MODE_BEAT;
    pulse_go;
    check_v(32'(limit_hit));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
